// File: rtl/match_ctrl.sv
// match_ctrl -- rally-scoring match controller for the volleyball game.
//
// Serves the ball after a hold-off delay, counts edge-detected touches per
// side, awards points on ground contact or over-touching, detects a win by
// a minimum score with a minimum lead (or score saturation) and restarts
// the match on request.
//
// Ports:
//   pclk        pixel clock; everything runs on its rising edge
//   rst         asynchronous active-low reset
//   start       match start/restart request (level, honoured in IDLE/OVER)
//   gnd_col     ball touched the ground
//   ball_side   half holding the ball (0 = player 1, 1 = player 2)
//   pl1_col     player 1 / ball overlap (level)
//   pl2_col     player 2 / ball overlap (level)
//   score_pl1   player 1 score
//   score_pl2   player 2 score
//   serve_side  server of the next/current rally
//   serve_req   one-cycle launch pulse on entry to the rally
//   freeze      hold ball physics (low only during a rally)
//   game_over   match finished
//   winner      match winner, valid while game_over
//   state       encoded FSM state for debug
module match_ctrl #(
  parameter int SCORE_W     = 5,
  parameter int WIN_POINTS  = 15,
  parameter int WIN_MARGIN  = 2,
  parameter int MAX_TOUCH   = 3,
  parameter int SERVE_DELAY = 65000000
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               start,
  input  logic               gnd_col,
  input  logic               ball_side,
  input  logic               pl1_col,
  input  logic               pl2_col,
  output logic [SCORE_W-1:0] score_pl1,
  output logic [SCORE_W-1:0] score_pl2,
  output logic               serve_side,
  output logic               serve_req,
  output logic               freeze,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam int DLY_W = $clog2(SERVE_DELAY) + 1;
  localparam int TC_W  = $clog2(MAX_TOUCH + 2);

  localparam logic [DLY_W-1:0]   DLY_LAST  = DLY_W'(SERVE_DELAY - 1);
  localparam logic [TC_W-1:0]    TC_LIMIT  = TC_W'(MAX_TOUCH);
  localparam logic [TC_W-1:0]    TC_SAT    = TC_W'(MAX_TOUCH + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_PTS   = SCORE_W'(WIN_POINTS);
  localparam logic [SCORE_W-1:0] WIN_MRG   = SCORE_W'(WIN_MARGIN);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    RALLY      = 3'd2,
    POINT      = 3'd3,
    OVER       = 3'd4
  } state_t;

  state_t             state_q, state_nxt;
  logic [DLY_W-1:0]   dly_q, dly_nxt;
  logic [TC_W-1:0]    tc_q, tc_nxt;
  logic               last_q, last_nxt;
  logic               pl1_prev_q, pl2_prev_q;
  logic [SCORE_W-1:0] score_pl1_nxt, score_pl2_nxt;
  logic               serve_side_nxt, serve_req_nxt, freeze_nxt;
  logic               game_over_nxt, winner_nxt;

  // Combinational helpers for the rally and point evaluation
  logic               rise1, rise2, toucher, point, point_to;
  logic [TC_W-1:0]    tc_new;
  logic [SCORE_W-1:0] win_score, lose_score;
  logic               match_won;

  // Edge detectors track the overlaps in every state, so an overlap that is
  // already present when the rally starts is never seen as a fresh touch.
  assign rise1 = pl1_col & ~pl1_prev_q;
  assign rise2 = pl2_col & ~pl2_prev_q;
  assign state = state_q;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      tc_q       <= '0;
      last_q     <= 1'b0;
      pl1_prev_q <= 1'b0;
      pl2_prev_q <= 1'b0;
      score_pl1  <= '0;
      score_pl2  <= '0;
      serve_side <= 1'b0;
      serve_req  <= 1'b0;
      freeze     <= 1'b1;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      dly_q      <= dly_nxt;
      tc_q       <= tc_nxt;
      last_q     <= last_nxt;
      pl1_prev_q <= pl1_col;
      pl2_prev_q <= pl2_col;
      score_pl1  <= score_pl1_nxt;
      score_pl2  <= score_pl2_nxt;
      serve_side <= serve_side_nxt;
      serve_req  <= serve_req_nxt;
      freeze     <= freeze_nxt;
      game_over  <= game_over_nxt;
      winner     <= winner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    dly_nxt        = dly_q;
    tc_nxt         = tc_q;
    last_nxt       = last_q;
    score_pl1_nxt  = score_pl1;
    score_pl2_nxt  = score_pl2;
    serve_side_nxt = serve_side;
    serve_req_nxt  = 1'b0;
    game_over_nxt  = game_over;
    winner_nxt     = winner;
    toucher        = rise2;
    tc_new         = tc_q;
    point          = 1'b0;
    point_to       = 1'b0;

    // In POINT, serve_side already names the player who just scored.
    win_score  = serve_side ? score_pl2 : score_pl1;
    lose_score = serve_side ? score_pl1 : score_pl2;
    match_won  = ((win_score >= WIN_PTS) && (win_score > lose_score) &&
                  ((win_score - lose_score) >= WIN_MRG)) ||
                 (win_score == SCORE_MAX);

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          score_pl1_nxt  = '0;
          score_pl2_nxt  = '0;
          serve_side_nxt = 1'b0;
          dly_nxt        = '0;
          game_over_nxt  = 1'b0;
          state_nxt      = SERVE_WAIT;
        end
      end
      SERVE_WAIT: begin
        if (dly_q == DLY_LAST) begin
          serve_req_nxt = 1'b1;
          tc_nxt        = '0;
          last_nxt      = 1'b0;
          state_nxt     = RALLY;
        end else begin
          dly_nxt = dly_q + DLY_W'(1);
        end
      end
      RALLY: begin
        if (gnd_col) begin
          // Ground contact outranks any touch fault in the same cycle.
          point    = 1'b1;
          point_to = ~ball_side;
        end else if (rise1 ^ rise2) begin
          // Simultaneous rises from both players cancel out.
          if (toucher == last_q) begin
            tc_new = (tc_q == TC_SAT) ? tc_q : tc_q + TC_W'(1);
          end else begin
            tc_new = TC_W'(1);
          end
          tc_nxt   = tc_new;
          last_nxt = toucher;
          if (tc_new > TC_LIMIT) begin
            point    = 1'b1;
            point_to = ~toucher;
          end
        end
        if (point) begin
          if (point_to) begin
            score_pl2_nxt = (score_pl2 == SCORE_MAX) ? score_pl2 : score_pl2 + SCORE_W'(1);
          end else begin
            score_pl1_nxt = (score_pl1 == SCORE_MAX) ? score_pl1 : score_pl1 + SCORE_W'(1);
          end
          serve_side_nxt = point_to;
          state_nxt      = POINT;
        end
      end
      POINT: begin
        if (match_won) begin
          game_over_nxt = 1'b1;
          winner_nxt    = serve_side;
          state_nxt     = OVER;
        end else begin
          dly_nxt   = '0;
          state_nxt = SERVE_WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase

    freeze_nxt = (state_nxt != RALLY);
  end

endmodule

// File: tb/tb_match_ctrl.sv
module tb_match_ctrl;

  localparam int SCORE_W = 5;

  logic               pclk = 1'b0;
  logic               rst;
  logic               start, gnd_col, ball_side, pl1_col, pl2_col;
  logic [SCORE_W-1:0] score_pl1, score_pl2;
  logic               serve_side, serve_req, freeze, game_over, winner;
  logic [2:0]         state;

  int checks = 0;
  int failures = 0;

  match_ctrl #(
    .SCORE_W(SCORE_W), .WIN_POINTS(3), .WIN_MARGIN(2),
    .MAX_TOUCH(3), .SERVE_DELAY(4)
  ) dut (
    .pclk(pclk), .rst(rst), .start(start), .gnd_col(gnd_col),
    .ball_side(ball_side), .pl1_col(pl1_col), .pl2_col(pl2_col),
    .score_pl1(score_pl1), .score_pl2(score_pl2), .serve_side(serve_side),
    .serve_req(serve_req), .freeze(freeze), .game_over(game_over),
    .winner(winner), .state(state)
  );

  always #5 pclk = ~pclk;

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Collision pulse: high for hi cycles, then low for lo cycles.
  task automatic pulse(input bit p2, input int hi, input int lo);
    if (p2) pl2_col = 1'b1; else pl1_col = 1'b1;
    repeat (hi) tick();
    if (p2) pl2_col = 1'b0; else pl1_col = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wait_rally(input string tag);
    int n;
    n = 0;
    while (state !== 3'd2 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL %s_reach_rally: state=%0d required=2", tag, state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; gnd_col = 0; ball_side = 0; pl1_col = 0; pl2_col = 0;
    tick(); tick();
    checks++;
    if ({state, score_pl1, score_pl2, serve_side, serve_req, freeze, game_over, winner}
        !== {3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: state=%0d s1=%0d s2=%0d ss=%b sr=%b fr=%b go=%b w=%b",
               state, score_pl1, score_pl2, serve_side, serve_req, freeze, game_over, winner);
    end
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL idle_hold: state=%0d required=0", state);
    end
  endtask

  task automatic test_start_serve();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || freeze !== 1'b1 || score_pl1 !== 0 || score_pl2 !== 0) begin
      failures++;
      $display("FAIL start_entry: state=%0d fr=%b s=%0d/%0d required 1,1,0/0",
               state, freeze, score_pl1, score_pl2);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (state !== 3'd1 || serve_req !== 1'b0 || freeze !== 1'b1) begin
        failures++;
        $display("FAIL serve_wait_%0d: state=%0d sr=%b fr=%b required 1,0,1",
                 i, state, serve_req, freeze);
      end
    end
    tick();
    checks++;
    if (state !== 3'd2 || serve_req !== 1'b1 || freeze !== 1'b0) begin
      failures++;
      $display("FAIL serve_pulse: state=%0d sr=%b fr=%b required 2,1,0",
               state, serve_req, freeze);
    end
    tick();
    checks++;
    if (serve_req !== 1'b0 || freeze !== 1'b0) begin
      failures++;
      $display("FAIL serve_one_cycle: sr=%b fr=%b required 0,0", serve_req, freeze);
    end
  endtask

  task automatic test_ground();
    ball_side = 1'b0; gnd_col = 1'b1;
    tick();
    gnd_col = 1'b0;
    checks++;
    if (state !== 3'd3 || score_pl2 !== 5'd1 || score_pl1 !== 5'd0 ||
        serve_side !== 1'b1 || freeze !== 1'b1) begin
      failures++;
      $display("FAIL ground_point: state=%0d s=%0d/%0d ss=%b fr=%b required 3,0/1,1,1",
               state, score_pl1, score_pl2, serve_side, freeze);
    end
    tick();
    checks++;
    if (state !== 3'd1 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL ground_next: state=%0d go=%b required 1,0", state, game_over);
    end
    wait_rally("ground");
  endtask

  task automatic test_touch_fault();
    for (int p = 0; p < 4; p++) begin
      pl1_col = 1'b1;
      tick();
      checks++;
      if (p < 3) begin
        if (state !== 3'd2) begin
          failures++;
          $display("FAIL touch_%0d_no_fault: state=%0d required=2", p + 1, state);
        end
      end else if (state !== 3'd3 || score_pl2 !== 5'd2 || score_pl1 !== 5'd0 || serve_side !== 1'b1) begin
        failures++;
        $display("FAIL touch_fault: state=%0d s=%0d/%0d ss=%b required 3,0/2,1",
                 state, score_pl1, score_pl2, serve_side);
      end
      repeat (9) tick();
      pl1_col = 1'b0;
      repeat (2) tick();
    end
    wait_rally("touch");
  endtask

  task automatic test_touch_reset();
    pulse(0, 10, 2);
    pulse(0, 10, 2);
    pulse(1, 10, 2);
    pulse(0, 10, 2);
    pulse(0, 10, 2);
    checks++;
    if (state !== 3'd2 || score_pl1 !== 5'd0 || score_pl2 !== 5'd2) begin
      failures++;
      $display("FAIL other_resets_count: state=%0d s=%0d/%0d required 2,0/2",
               state, score_pl1, score_pl2);
    end
    ball_side = 1'b1; gnd_col = 1'b1;
    tick();
    gnd_col = 1'b0;
    checks++;
    if (score_pl1 !== 5'd1 || score_pl2 !== 5'd2 || serve_side !== 1'b0) begin
      failures++;
      $display("FAIL ground_side1: s=%0d/%0d ss=%b required 1/2,0", score_pl1, score_pl2, serve_side);
    end
    wait_rally("side1");
  endtask

  task automatic test_same_cycle();
    pulse(0, 10, 2);
    pulse(0, 10, 2);
    pulse(0, 10, 2);
    pl1_col = 1'b1; gnd_col = 1'b1; ball_side = 1'b1;
    tick();
    gnd_col = 1'b0; pl1_col = 1'b0;
    checks++;
    if (state !== 3'd3 || score_pl1 !== 5'd2 || score_pl2 !== 5'd2 || serve_side !== 1'b0) begin
      failures++;
      $display("FAIL ground_priority: state=%0d s=%0d/%0d ss=%b required 3,2/2,0",
               state, score_pl1, score_pl2, serve_side);
    end
    wait_rally("prio");
  endtask

  task automatic test_win_restart();
    ball_side = 1'b1; gnd_col = 1'b1;
    tick();
    gnd_col = 1'b0;
    tick();
    checks++;
    if (state !== 3'd1 || game_over !== 1'b0 || score_pl1 !== 5'd3) begin
      failures++;
      $display("FAIL no_win_3_2: state=%0d go=%b s1=%0d required 1,0,3", state, game_over, score_pl1);
    end
    wait_rally("win");
    gnd_col = 1'b1;
    tick();
    gnd_col = 1'b0;
    tick();
    checks++;
    if (state !== 3'd4 || game_over !== 1'b1 || winner !== 1'b0 || freeze !== 1'b1 ||
        score_pl1 !== 5'd4 || score_pl2 !== 5'd2) begin
      failures++;
      $display("FAIL win_4_2: state=%0d go=%b w=%b fr=%b s=%0d/%0d required 4,1,0,1,4/2",
               state, game_over, winner, freeze, score_pl1, score_pl2);
    end
    gnd_col = 1'b1; ball_side = 1'b0;
    tick(); tick();
    gnd_col = 1'b0;
    checks++;
    if (state !== 3'd4 || score_pl1 !== 5'd4 || score_pl2 !== 5'd2) begin
      failures++;
      $display("FAIL over_hold: state=%0d s=%0d/%0d required 4,4/2", state, score_pl1, score_pl2);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || score_pl1 !== 5'd0 || score_pl2 !== 5'd0 ||
        game_over !== 1'b0 || serve_side !== 1'b0) begin
      failures++;
      $display("FAIL restart: state=%0d s=%0d/%0d go=%b ss=%b required 1,0/0,0,0",
               state, score_pl1, score_pl2, game_over, serve_side);
    end
  endtask

  task automatic test_async_reset();
    wait_rally("areset");
    ball_side = 1'b0; gnd_col = 1'b1;
    tick();
    gnd_col = 1'b0;
    wait_rally("areset2");
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({state, score_pl1, score_pl2, serve_side, serve_req, freeze, game_over, winner}
        !== {3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: state=%0d s=%0d/%0d ss=%b sr=%b fr=%b go=%b w=%b",
               state, score_pl1, score_pl2, serve_side, serve_req, freeze, game_over, winner);
    end
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_held_overlap();
    pl1_col = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_rally("held");
    checks++;
    if (serve_req !== 1'b1) begin
      failures++;
      $display("FAIL held_serve_pulse: sr=%b required=1", serve_req);
    end
    repeat (3) tick();
    pl1_col = 1'b0;
    repeat (2) tick();
    pulse(0, 10, 2);
    pulse(0, 10, 2);
    pulse(0, 10, 2);
    checks++;
    if (state !== 3'd2 || score_pl1 !== 5'd0 || score_pl2 !== 5'd0) begin
      failures++;
      $display("FAIL held_no_touch: state=%0d s=%0d/%0d required 2,0/0", state, score_pl1, score_pl2);
    end
  endtask

  initial begin
    test_reset();
    test_start_serve();
    test_ground();
    test_touch_fault();
    test_touch_reset();
    test_same_cycle();
    test_win_restart();
    test_async_reset();
    test_held_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
